// File: rtl/trade_logger.sv
// Trade event logger: detects distinct matches, timestamps them, queues them in a
// show-ahead FIFO drained by valid/ready, and keeps running trade statistics.
module trade_logger #(
    parameter int DEPTH = 16,
    parameter int TS_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     match_in,
    input  logic [7:0]               trade_price_in,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [7:0]               out_price,
    output logic [TS_W-1:0]          out_ts,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [15:0]              trade_count,
    output logic [7:0]               drop_count,
    output logic [7:0]               last_price,
    output logic [7:0]               high_price,
    output logic [7:0]               low_price,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);

    logic [TS_W-1:0] ts_q, ts_d;
    logic            prev_match_q, prev_match_d;
    logic [7:0]      prev_price_q, prev_price_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic [15:0]     trade_count_q, trade_count_d;
    logic [7:0]      drop_count_q, drop_count_d;
    logic [7:0]      last_q, last_d, high_q, high_d, low_q, low_d;
    logic            overflow_q, overflow_d;

    logic [7:0]      mem_price_q [DEPTH];
    logic [TS_W-1:0] mem_ts_q    [DEPTH];

    logic evt, pop, full, push, drop;

    always_comb begin
        evt  = match_in && (!prev_match_q || (trade_price_in != prev_price_q));
        pop  = (count_q != '0) && out_ready;
        full = (count_q == (AW+1)'(DEPTH));
        push = evt && (!full || pop);
        drop = evt && !push;

        ts_d          = ts_q + TS_W'(1);
        prev_match_d  = match_in;
        prev_price_d  = match_in ? trade_price_in : prev_price_q;
        rd_ptr_d      = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        wr_ptr_d      = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        count_d       = count_q;
        if (push && !pop)
            count_d = count_q + (AW+1)'(1);
        else if (pop && !push)
            count_d = count_q - (AW+1)'(1);

        trade_count_d = (push && trade_count_q != 16'hFFFF) ? trade_count_q + 16'd1 : trade_count_q;
        drop_count_d  = (drop && drop_count_q != 8'hFF) ? drop_count_q + 8'd1 : drop_count_q;
        overflow_d    = overflow_q || drop;

        // Statistics track every event, including those lost to a full FIFO.
        last_d = evt ? trade_price_in : last_q;
        high_d = (evt && trade_price_in > high_q) ? trade_price_in : high_q;
        low_d  = (evt && trade_price_in < low_q)  ? trade_price_in : low_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ts_q          <= '0;
            prev_match_q  <= 1'b0;
            prev_price_q  <= 8'h00;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            trade_count_q <= 16'h0000;
            drop_count_q  <= 8'h00;
            last_q        <= 8'h00;
            high_q        <= 8'h00;
            low_q         <= 8'hFF;
            overflow_q    <= 1'b0;
        end else begin
            ts_q          <= ts_d;
            prev_match_q  <= prev_match_d;
            prev_price_q  <= prev_price_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            trade_count_q <= trade_count_d;
            drop_count_q  <= drop_count_d;
            last_q        <= last_d;
            high_q        <= high_d;
            low_q         <= low_d;
            overflow_q    <= overflow_d;
        end
    end

    // Storage needs no reset; pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem_price_q[wr_ptr_q] <= trade_price_in;
            mem_ts_q[wr_ptr_q]    <= ts_q;
        end
    end

    assign out_valid   = (count_q != '0);
    assign out_price   = out_valid ? mem_price_q[rd_ptr_q] : 8'h00;
    assign out_ts      = out_valid ? mem_ts_q[rd_ptr_q] : '0;
    assign fifo_count  = count_q;
    assign trade_count = trade_count_q;
    assign drop_count  = drop_count_q;
    assign last_price  = last_q;
    assign high_price  = high_q;
    assign low_price   = low_q;
    assign overflow    = overflow_q;
endmodule
